mux_piso_sequencer: RTL and testbench

//  Parallel-in/serial-out sequencer feeding the structural mux tree: captures a WIDTH-bit word,

---
 rtl/mux_piso_sequencer.sv | 92 +++++++++
 tb/tb_mux_piso_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_piso_sequencer.sv
// Parallel-in/serial-out sequencer: captures a WIDTH-bit word and walks a select index across it,
// presenting word[sel] as a valid/ready serial stream; sel is exported for an external mux tree.
module mux_piso_sequencer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last
);

    localparam logic [SEL_W-1:0] START_IDX = (LSB_FIRST != 0) ? '0 : SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] END_IDX   = (LSB_FIRST != 0) ? SEL_W'(WIDTH - 1) : '0;
    localparam logic [SEL_W-1:0] STEP_ONE  = SEL_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_n;
    logic [SEL_W-1:0] sel_n;
    logic             accept;
    logic             beat;

    // Handshake and stream outputs are decoded from the registered state, word and index so a
    // reset or a stall is reflected in the same cycle without an extra pipeline stage.
    assign out_valid = (state == SHIFT);
    assign out_last  = (state == SHIFT) && (sel == END_IDX);
    assign out_bit   = word[sel];
    assign in_ready  = (state == IDLE) || (out_last && out_ready);
    assign accept    = in_valid && in_ready;
    assign beat      = out_valid && out_ready;

    // State, word and select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            word  <= '0;
            sel   <= START_IDX;
        end else begin
            state <= state_n;
            word  <= word_n;
            sel   <= sel_n;
        end
    end

    // Next-state: capture on acceptance, step the index on each beat, reload only on a new word.
    always_comb begin
        state_n = state;
        word_n  = word;
        sel_n   = sel;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    word_n  = in_data;
                    sel_n   = START_IDX;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (out_last) begin
                        if (accept) begin
                            word_n = in_data;
                            sel_n  = START_IDX;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (LSB_FIRST != 0) begin
                        sel_n = sel + STEP_ONE;
                    end else begin
                        sel_n = sel - STEP_ONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_piso_sequencer.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor pops and compares them.
module tb_mux_piso_sequencer;

    typedef struct {
        logic       b;
        logic       l;
        logic [3:0] s;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  in_valid = 2'b00;
    logic [1:0]  in_ready;
    logic [15:0] in_data [2];
    logic [3:0]  sel [2];
    logic [1:0]  out_valid;
    logic [1:0]  out_ready = 2'b11;
    logic [1:0]  out_bit;
    logic [1:0]  out_last;

    beat_t q0[$];
    beat_t q1[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    bp_en    = 1'b0;

    bit         prev_stall [2];
    logic [3:0] prev_sel   [2];
    logic       prev_bit   [2];
    logic       prev_last  [2];

    always #5 clk = ~clk;

    mux_piso_sequencer #(.WIDTH(16), .SEL_W(4), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .sel(sel[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_bit(out_bit[0]), .out_last(out_last[0])
    );

    mux_piso_sequencer #(.WIDTH(16), .SEL_W(4), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .sel(sel[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_bit(out_bit[1]), .out_last(out_last[1])
    );

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // seq bit i is the i-th bit expected on the wire; n beats are queued.
    task automatic push_word(input int d, input logic [15:0] seq, input bit lsb, input int n);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.b = seq[i];
            e.l = (i == 15);
            e.s = lsb ? 4'(i) : 4'(15 - i);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Entered just after a posedge; returns just after the accepting posedge with in_valid low.
    task automatic send(input int d, input logic [15:0] w, input bit hold);
        bit ok = 1'b0;
        in_data[d]  = w;
        in_valid[d] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) expect_eq("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) in_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        bit done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) expect_eq("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
        expect_eq("idle_after_word", 32'(out_valid[d]), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Backpressure pattern 1,0,0,1 on the LSB-first instance.
    initial begin
        int k = 0;
        logic [3:0] pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_ready[0] = pat[3 - k];
                k = (k + 1) % 4;
            end else begin
                k = 0;
            end
        end
    end

    // Monitor: compare every beat against the scoreboard and hold stalled outputs steady.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst && prev_stall[d] && out_valid[d]) begin
                    expect_eq("stall_sel", 32'(sel[d]), 32'(prev_sel[d]));
                    expect_eq("stall_bit", 32'(out_bit[d]), 32'(prev_bit[d]));
                    expect_eq("stall_last", 32'(out_last[d]), 32'(prev_last[d]));
                end
                if (out_valid[d] && out_ready[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        expect_eq("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        expect_eq("beat_bit", 32'(out_bit[d]), 32'(e.b));
                        expect_eq("beat_last", 32'(out_last[d]), 32'(e.l));
                        expect_eq("beat_sel", 32'(sel[d]), 32'(e.s));
                    end
                end
                prev_stall[d] = out_valid[d] && !out_ready[d];
                prev_sel[d]   = sel[d];
                prev_bit[d]   = out_bit[d];
                prev_last[d]  = out_last[d];
            end
        end
    end

    initial begin
        in_data[0] = '0;
        in_data[1] = '0;

        // Reset and idle values
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        expect_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
        expect_eq("rst_in_ready", 32'(in_ready[0]), 32'd1);
        expect_eq("rst_sel", 32'(sel[0]), 32'd0);
        expect_eq("rst_out_last", 32'(out_last[0]), 32'd0);
        expect_eq("rst_out_bit", 32'(out_bit[0]), 32'd0);
        expect_eq("rst_sel_msb", 32'(sel[1]), 32'd15);
        @(posedge clk);
        #1;

        // Single word, LSB first: bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
        push_word(0, 16'hA5C3, 1'b1, 16);
        send(0, 16'hA5C3, 1'b0);
        drain(0);

        // Back-to-back FFFF then 0000 with in_valid held
        push_word(0, 16'hFFFF, 1'b1, 16);
        push_word(0, 16'h0000, 1'b1, 16);
        send(0, 16'hFFFF, 1'b1);
        in_data[0] = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            expect_eq("b2b_contiguous", 32'(out_valid[0]), 32'd1);
            if (i < 16) expect_eq("b2b_in_ready", 32'(in_ready[0]), 32'(i == 15));
            if (i == 15) begin
                @(posedge clk);
                #1 in_valid[0] = 1'b0;
            end
        end
        drain(0);

        // Backpressure on 8001
        bp_en = 1'b1;
        push_word(0, 16'h8001, 1'b1, 16);
        send(0, 16'h8001, 1'b0);
        drain(0);
        bp_en = 1'b0;
        @(posedge clk);
        #1 out_ready[0] = 1'b1;

        // MSB-first instance: 8001 emits 1, fourteen 0s, 1
        push_word(1, 16'h8001, 1'b0, 16);
        send(1, 16'h8001, 1'b0);
        drain(1);

        // Reset after the fifth beat of 00F0, then a clean 0001
        push_word(0, 16'h00F0, 1'b1, 5);
        send(0, 16'h00F0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        expect_eq("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        expect_eq("midrst_sel", 32'(sel[0]), 32'd0);
        expect_eq("midrst_out_last", 32'(out_last[0]), 32'd0);
        expect_eq("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        expect_eq("post_rst_idle", 32'(out_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        push_word(0, 16'h0001, 1'b1, 16);
        send(0, 16'h0001, 1'b0);
        drain(0);

        expect_eq("q0_empty", 32'(q0.size()), 32'd0);
        expect_eq("q1_empty", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
